// File: rtl/mux_rr_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_scheduler_pkg
// Description : Shared definitions for the round-robin mux scheduler:
//               FSM state encoding, requester count and pointer reset value.
// Revision    : 1.0  initial release
// ============================================================================
package mux_rr_scheduler_pkg;

  localparam int          N_REQ   = 8;      // number of requesters
  localparam int          IDX_W   = 3;      // width of a requester index
  localparam logic [2:0]  PTR_RST = 3'd7;   // "last served" after reset

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,   // nothing offered, VALID=0, GNT=0
    ST_WAIT = 1'b1    // word offered, VALID=1, GNT one-hot at SEL
  } state_t;

endpackage : mux_rr_scheduler_pkg
`default_nettype wire

// File: rtl/mux_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_scheduler_if
// Description : Request/data/grant bundle of the round-robin mux scheduler.
//               master : requester/consumer side (drives ud, req, din, ready)
//               slave  : scheduler side (drives gnt, sel, data_out, valid,
//                        xfer_cnt, err)
// Revision    : 1.0  initial release
// ============================================================================
interface mux_rr_scheduler_if #(
  parameter int DW = 8
);
  import mux_rr_scheduler_pkg::*;

  logic                 ud;              // 1 = ascending search, 0 = descending
  logic [N_REQ-1:0]     req;             // per-requester request
  logic [DW-1:0]        din [N_REQ];     // requester data words I0..I7
  logic                 ready;           // consumer accepts data_out
  logic [N_REQ-1:0]     gnt;             // one-hot grant
  logic [IDX_W-1:0]     sel;             // granted index
  logic [DW-1:0]        data_out;        // registered granted word
  logic                 valid;           // data_out holds an offered word
  logic [7:0]           xfer_cnt;        // completed transfers (wrapping)
  logic                 err;             // timeout abandonment pulse

  modport master (
    output ud, req, din, ready,
    input  gnt, sel, data_out, valid, xfer_cnt, err
  );

  modport slave (
    input  ud, req, din, ready,
    output gnt, sel, data_out, valid, xfer_cnt, err
  );

endinterface : mux_rr_scheduler_if
`default_nettype wire

// File: rtl/mux_rr_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin search. Starting one step past ptr
//               (ptr+1 upward when ud=1, ptr-1 downward when ud=0) and
//               visiting all 8 indices modulo 8, returns the first active
//               request. ptr itself is visited last, so it wins only when it
//               is the sole requester.
// Ports       : req[7:0] in, ptr[2:0] in, ud in, win[2:0] out, any out
// Revision    : 1.0  initial release
// ============================================================================
module rr_pick
  import mux_rr_scheduler_pkg::*;
(
  input  wire logic [N_REQ-1:0] req,
  input  wire logic [IDX_W-1:0] ptr,
  input  wire logic             ud,
  output logic      [IDX_W-1:0] win,
  output logic                  any
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    win = '0;
    any = 1'b0;
    idx = '0;
    // Walk from the farthest step back to the nearest so the nearest active
    // request is the last (and therefore winning) assignment.
    for (int k = N_REQ; k >= 1; k--) begin
      idx = ud ? (ptr + IDX_W'(k)) : (ptr - IDX_W'(k));
      if (req[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mux_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_scheduler
// Description : 8-way round-robin scheduler with registered data mux and a
//               valid/ready output handshake. Back-to-back grants without a
//               bubble; the offer is frozen while waiting for ready.
// Ports       : clock        - rising-edge clock
//               clr          - synchronous active-high reset
//               bus (slave)  - ud, req, din[8], ready in;
//                              gnt, sel, data_out, valid, xfer_cnt, err out
// Config      : MUX_RR_SCHED_TIMEOUT_EN - when defined, a grant held TIMEOUT
//               WAIT cycles without ready is abandoned and err pulses.
// Revision    : 1.0  initial release
// ============================================================================
module mux_rr_scheduler
  import mux_rr_scheduler_pkg::*;
#(
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  wire logic          clock,
  input  wire logic          clr,
  mux_rr_scheduler_if.slave  bus
);

  if (DW < 1 || TIMEOUT < 1) begin : g_param_check
    $error("mux_rr_scheduler: DW and TIMEOUT must be at least 1");
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  logic [IDX_W-1:0] sel_q,   sel_d;
  logic [DW-1:0]    data_q,  data_d;
  logic [7:0]       xfer_q,  xfer_d;

  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] pick_win;
  logic             pick_any;
  logic             xfer;

  // On a transfer the served index becomes the new pointer in the same
  // edge, so the back-to-back search must start from sel rather than ptr.
  assign pick_ptr = (state_q == ST_WAIT) ? sel_q : ptr_q;
  assign xfer     = (state_q == ST_WAIT) && bus.ready;

  rr_pick u_rr_pick (
    .req (bus.req),
    .ptr (pick_ptr),
    .ud  (bus.ud),
    .win (pick_win),
    .any (pick_any)
  );

`ifdef MUX_RR_SCHED_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);

  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           err_q,  err_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    xfer_d  = xfer_q;
`ifdef MUX_RR_SCHED_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    err_d   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        // ready is meaningless here: nothing is being offered.
        if (pick_any) begin
          state_d = ST_WAIT;
          sel_d   = pick_win;
          data_d  = bus.din[pick_win];
`ifdef MUX_RR_SCHED_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end
      end

      ST_WAIT: begin
        if (xfer) begin
          ptr_d  = sel_q;
          xfer_d = xfer_q + 8'd1;
          if (pick_any) begin
            sel_d  = pick_win;
            data_d = bus.din[pick_win];
`ifdef MUX_RR_SCHED_TIMEOUT_EN
            tcnt_d = '0;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
`ifdef MUX_RR_SCHED_TIMEOUT_EN
        else if (tcnt_q == TCW'(TIMEOUT - 1)) begin
          // Last permitted WAIT cycle without ready: drop the offer and
          // move the pointer past the stalled requester.
          state_d = ST_IDLE;
          ptr_d   = sel_q;
          err_d   = 1'b1;
          tcnt_d  = '0;
        end else begin
          tcnt_d  = tcnt_q + TCW'(1);
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      state_q <= ST_IDLE;
      ptr_q   <= PTR_RST;
      sel_q   <= '0;
      data_q  <= '0;
      xfer_q  <= '0;
`ifdef MUX_RR_SCHED_TIMEOUT_EN
      tcnt_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      xfer_q  <= xfer_d;
`ifdef MUX_RR_SCHED_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.valid    = (state_q == ST_WAIT);
  assign bus.gnt      = (state_q == ST_WAIT) ? (N_REQ'(1) << sel_q) : '0;
  assign bus.sel      = sel_q;
  assign bus.data_out = data_q;
  assign bus.xfer_cnt = xfer_q;
`ifdef MUX_RR_SCHED_TIMEOUT_EN
  assign bus.err      = err_q;
`else
  assign bus.err      = 1'b0;
`endif

endmodule : mux_rr_scheduler
`default_nettype wire

// File: tb/tb_mux_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_scheduler
// Description : Self-checking bench for mux_rr_scheduler. A table of
//               hand-computed vectors covers arbitration order in both
//               directions, back-to-back grants and idle handling; short
//               hand-written sequences cover the frozen offer, counter wrap,
//               reset during a transfer and the optional timeout.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mux_rr_scheduler;
  import mux_rr_scheduler_pkg::*;

  logic clk;
  logic clr;
  int   n_checks;
  int   n_pass;

  mux_rr_scheduler_if #(.DW(8)) bus ();

  mux_rr_scheduler #(.DW(8), .TIMEOUT(15)) dut (
    .clock (clk),
    .clr   (clr),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ud;
    logic [7:0] req;
    logic       ready;
    logic [7:0] gnt;
    logic       valid;
    logic [7:0] data;
    logic [7:0] xfer;
  } vec_t;

  vec_t tbl [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic set_default_data();
    for (int k = 0; k < N_REQ; k++) bus.din[k] = 8'hA0 + 8'(k);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    clr       = 1'b1;
    bus.ud    = 1'b1;
    bus.req   = '0;
    bus.ready = 1'b0;
    set_default_data();

    // Table rows: inputs applied before an edge, outputs expected after it.
    //               ud    req    rdy   gnt    v     data   xfer
    tbl[0]  = '{1'b1, 8'h0A, 1'b1, 8'h02, 1'b1, 8'hA1, 8'd0};
    tbl[1]  = '{1'b1, 8'h0A, 1'b1, 8'h08, 1'b1, 8'hA3, 8'd1};
    tbl[2]  = '{1'b1, 8'h0A, 1'b1, 8'h02, 1'b1, 8'hA1, 8'd2};
    tbl[3]  = '{1'b1, 8'h0A, 1'b1, 8'h08, 1'b1, 8'hA3, 8'd3};
    tbl[4]  = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 8'hA3, 8'd4};
    tbl[5]  = '{1'b0, 8'h04, 1'b1, 8'h04, 1'b1, 8'hA2, 8'd4};
    tbl[6]  = '{1'b0, 8'hFF, 1'b1, 8'h02, 1'b1, 8'hA1, 8'd5};
    tbl[7]  = '{1'b0, 8'hFF, 1'b1, 8'h01, 1'b1, 8'hA0, 8'd6};
    tbl[8]  = '{1'b0, 8'hFF, 1'b1, 8'h80, 1'b1, 8'hA7, 8'd7};
    tbl[9]  = '{1'b0, 8'hFF, 1'b1, 8'h40, 1'b1, 8'hA6, 8'd8};
    tbl[10] = '{1'b0, 8'hFF, 1'b1, 8'h20, 1'b1, 8'hA5, 8'd9};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 8'h20, 1'b1, 8'hA5, 8'd9};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'hA5, 8'd10};

    // ---- reset state ----
    tick();
    tick();
    check("reset_valid", 32'(bus.valid),    32'd0);
    check("reset_gnt",   32'(bus.gnt),      32'd0);
    check("reset_sel",   32'(bus.sel),      32'd0);
    check("reset_data",  32'(bus.data_out), 32'd0);
    check("reset_xfer",  32'(bus.xfer_cnt), 32'd0);
    check("reset_err",   32'(bus.err),      32'd0);
    clr = 1'b0;

    // ---- table-driven arbitration sequence ----
    for (int i = 0; i < 13; i++) begin
      bus.ud    = tbl[i].ud;
      bus.req   = tbl[i].req;
      bus.ready = tbl[i].ready;
      tick();
      check($sformatf("row%0d_gnt", i),   32'(bus.gnt),      32'(tbl[i].gnt));
      check($sformatf("row%0d_valid", i), 32'(bus.valid),    32'(tbl[i].valid));
      check($sformatf("row%0d_data", i),  32'(bus.data_out), 32'(tbl[i].data));
      check($sformatf("row%0d_xfer", i),  32'(bus.xfer_cnt), 32'(tbl[i].xfer));
    end

    // ---- frozen offer: grant 4 (ptr=5, ascending wraps to 4) ----
    bus.din[4] = 8'h99;
    bus.ud     = 1'b1;
    bus.req    = 8'h10;
    bus.ready  = 1'b0;
    tick();
    check("hold_gnt",  32'(bus.gnt),      32'h10);
    check("hold_data", 32'(bus.data_out), 32'h99);
    bus.din[4] = 8'h00;
    bus.req    = 8'h00;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("hold%0d_data", c),  32'(bus.data_out), 32'h99);
      check($sformatf("hold%0d_valid", c), 32'(bus.valid),    32'd1);
      check($sformatf("hold%0d_sel", c),   32'(bus.sel),      32'd4);
    end
    bus.ready = 1'b1;
    tick();
    check("hold_xfer",       32'(bus.xfer_cnt), 32'd11);
    check("hold_idle_valid", 32'(bus.valid),    32'd0);
    bus.ready = 1'b0;
    set_default_data();

    // ---- sole requester, 256 transfers, counter wrap ----
    do_reset();
    bus.ud    = 1'b1;
    bus.req   = 8'h01;
    bus.ready = 1'b1;
    tick();
    check("wrap_first_gnt", 32'(bus.gnt), 32'h01);
    for (int t = 1; t <= 256; t++) begin
      tick();
      check($sformatf("wrap%0d_gnt", t), 32'(bus.gnt), 32'h01);
      if (t == 255) check("wrap_cnt255", 32'(bus.xfer_cnt), 32'd255);
    end
    check("wrap_cnt0",  32'(bus.xfer_cnt), 32'd0);
    check("wrap_valid", 32'(bus.valid),    32'd1);

    // ---- reset wins over a transfer on the same edge ----
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clrx_xfer",  32'(bus.xfer_cnt), 32'd0);
    check("clrx_valid", 32'(bus.valid),    32'd0);
    check("clrx_gnt",   32'(bus.gnt),      32'd0);
    check("clrx_data",  32'(bus.data_out), 32'd0);
    // ptr back at 7: ascending search picks index 0 first
    bus.req   = 8'hFF;
    bus.ready = 1'b0;
    tick();
    check("clrx_ptr_gnt", 32'(bus.gnt), 32'h01);

`ifdef MUX_RR_SCHED_TIMEOUT_EN
    // ---- timeout: WAIT entered on the previous edge, ready held low ----
    for (int c = 1; c < 15; c++) begin
      tick();
      check($sformatf("to%0d_valid", c), 32'(bus.valid), 32'd1);
      check($sformatf("to%0d_err", c),   32'(bus.err),   32'd0);
    end
    bus.req = 8'h00;
    tick();
    check("to_drop_valid", 32'(bus.valid),    32'd0);
    check("to_drop_gnt",   32'(bus.gnt),      32'd0);
    check("to_drop_err",   32'(bus.err),      32'd1);
    check("to_drop_xfer",  32'(bus.xfer_cnt), 32'd0);
    tick();
    check("to_err_pulse",  32'(bus.err),      32'd0);
    bus.req = 8'hFF;
    tick();
    check("to_skip_gnt",   32'(bus.gnt),      32'h02);
`else
    // ---- without timeout the offer persists indefinitely ----
    for (int c = 0; c < 20; c++) tick();
    check("nto_valid", 32'(bus.valid),    32'd1);
    check("nto_gnt",   32'(bus.gnt),      32'h01);
    check("nto_err",   32'(bus.err),      32'd0);
    check("nto_xfer",  32'(bus.xfer_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mux_rr_scheduler
`default_nettype wire
